// File: rtl/riscv_pkg.sv
// Shared fetch-path constants, the FIFO entry layout and the prefetch FSM states.
package riscv_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned ENTRY_W = PC_W + INST_W;

    localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] INST_NOP     = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pf_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Small circular FIFO with synchronous flush; reads return zero when empty.
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             pop_ok;
    logic             push_ok;

    // Never underflow, and only accept a write into a full FIFO when a slot frees up.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);

    assign rdata = (count != '0) ? mem[rptr] : '0;

    // Entry storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch queue: fetches from a combinational ROM into a FIFO and
// hands instructions to the core over valid/ready; redirects flush and restart.
module if_prefetch
    import riscv_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [PC_W-1:0]   rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    input  logic              inst_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pf_state_t        state_q;
    pf_state_t        state_d;
    logic             run;
    logic             push;
    logic             pop;
    logic [PC_W-1:0]  fetch_pc;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wentry;
    fetch_entry_t     rentry;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // IDLE holds off fetching for one cycle after reset so the ROM address settles.
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  run     = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop  = inst_valid_o && inst_ready_i;
    assign push = run && !redirect_i && ((count < CNT_W'(DEPTH)) || pop);

    // Fetch address: redirect target (word aligned) or advance on each capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           fetch_pc <= RESET_PC;
        else if (redirect_i) fetch_pc <= redirect_pc_i & ~PC_W'(3);
        else if (push)       fetch_pc <= fetch_pc + PC_W'(PC_STEP);
    end

    assign wentry.pc   = fetch_pc;
    assign wentry.inst = rom_inst_i;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (wentry),
        .rdata (rentry),
        .count (count)
    );

    assign rom_addr_o   = fetch_pc;
    assign inst_valid_o = (count != '0);
    assign inst_o       = rentry.inst;
    assign pc_o         = rentry.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_if_prefetch;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i;

    int checks = 0;
    int errors = 0;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rom_addr_o    (rom_addr_o),
        .rom_inst_i    (rom_inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign rom_inst_i = rom_f(rom_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst}, a fetch address and a "started" flag.
    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          mstarted;
    bit          mpop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mpc      = RPC;
            mstarted = 0;
        end else begin
            mpop = (mq.size() != 0) && inst_ready_i;
            if (redirect_i) begin
                mq.delete();
                mpc = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (mstarted && mq.size() < DEPTH) begin
                    mq.push_back({mpc, rom_f(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
            mstarted = 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            logic [63:0] head;
            head = (mq.size() != 0) ? mq[0] : 64'h0;
            chk("m_valid", 32'(inst_valid_o), 32'(mq.size() != 0));
            chk("m_pc",    pc_o,              head[63:32]);
            chk("m_inst",  inst_o,            head[31:0]);
            chk("m_addr",  rom_addr_o,        mpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, then release it halfway between edges.
    task automatic do_reset(input logic rdy);
        rstn          = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = rdy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        tick();
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    initial begin
        rstn          = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;
        #2;
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst",  inst_o,            32'h0);
        chk("rst_pc",    pc_o,              32'h0);
        chk("rst_addr",  rom_addr_o,        RPC);

        // Reset release with ready high: valid on the second edge, then 1/cycle.
        do_reset(1'b1);
        tick();
        chk("start_idle_valid", 32'(inst_valid_o), 32'h0);
        tick();
        chk("start_valid", 32'(inst_valid_o), 32'h1);
        chk("start_pc0",   pc_o,   32'h0);
        chk("start_inst0", inst_o, 32'hA5A5_0000);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("stream_pc",   pc_o,   32'(i * 4));
            chk("stream_inst", inst_o, rom_f(32'(i * 4)));
        end

        // Stall: ready low, FIFO fills and the fetch address parks at 0x10.
        do_reset(1'b0);
        repeat (8) tick();
        chk("stall_addr",  rom_addr_o,        32'h10);
        chk("stall_valid", 32'(inst_valid_o), 32'h1);
        chk("stall_pc",    pc_o,              32'h0);
        inst_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_pc", pc_o, 32'(i * 4));
        end
        // Full FIFO with ready held: one accepted per cycle, fetch advances each cycle.
        chk("full_addr", rom_addr_o, 32'h20);
        tick();
        chk("full_addr_next", rom_addr_o, 32'h24);

        // Redirect with three entries buffered.
        do_reset(1'b0);
        repeat (4) tick();
        do_redirect(32'h0000_0100);
        chk("redir_valid_off", 32'(inst_valid_o), 32'h0);
        chk("redir_addr",      rom_addr_o,        32'h100);
        tick();
        chk("redir_valid_on",  32'(inst_valid_o), 32'h1);
        chk("redir_pc0",       pc_o,              32'h100);
        inst_ready_i = 1'b1;
        tick();
        chk("redir_pc1", pc_o, 32'h104);

        // Misaligned target drops the low bits; pop coinciding with redirect is discarded.
        do_redirect(32'h0000_0103);
        chk("mis_valid_off", 32'(inst_valid_o), 32'h0);
        tick();
        chk("mis_pc", pc_o, 32'h100);
        chk("mis_inst", inst_o, 32'hA5A5_0100);

        // Wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        tick();
        chk("wrap_pc0", pc_o, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", pc_o, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", pc_o, 32'h0000_0000);

        // Asynchronous reset mid-stream takes effect before the next edge.
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("async_valid", 32'(inst_valid_o), 32'h0);
        chk("async_addr",  rom_addr_o,        RPC);
        chk("async_pc",    pc_o,              32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_async_idle", 32'(inst_valid_o), 32'h0);
        tick();
        chk("post_async_pc", pc_o, RPC);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction prefetch queue between the combinational instruction ROM and the riscv core.
- Drives the ROM address and captures the returned instruction with its PC into a small FIFO.
- Presents instructions to the core with a valid/ready handshake.
- Flushes and restarts fetch when the core redirects the PC (branch, jump or trap).

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- rom_addr_o  out  32  ROM fetch address; equals fetch_pc, combinational from a register.
- rom_inst_i  in  32  ROM instruction for rom_addr_o, valid in the same cycle (combinational ROM).
- redirect_i  in  1  core requests a fetch restart.
- redirect_pc_i  in  32  restart target.
- inst_valid_o  out  1  head entry is valid.
- inst_o  out  32  head instruction.
- pc_o  out  32  PC of the head instruction.
- inst_ready_i  in  1  core accepts the head entry this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset values:
  - fetch_pc = RESET_PC, count = 0, FIFO pointers = 0.
  - inst_valid_o = 0, inst_o = 0, pc_o = 0.
  - rom_addr_o = RESET_PC.
- Signal definitions:
  - pop = inst_valid_o & inst_ready_i.
  - push = !redirect_i & (count < DEPTH | pop).
- On push: write {fetch_pc, rom_inst_i} at the write pointer; fetch_pc += 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0).
- On pop: advance the read pointer.
- Count: count += push - pop, so simultaneous push and pop leave count unchanged, including when full.
- Outputs:
  - inst_valid_o = (count != 0), registered-state driven.
  - inst_o and pc_o are the head entry. When the FIFO is empty they hold 0; they are never stale data.
- Redirect has priority over everything:
  - count <= 0 and both pointers <= 0.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}; misaligned low bits are dropped.
  - No push that cycle.
  - A pop coinciding with a redirect still counts as accepted by the core; the entry is discarded.
- Latency:
  - First instruction is valid in the first cycle after rstn deasserts. The push happens on the first edge and valid is seen the cycle after that edge.
  - After a redirect, the target instruction is valid 2 cycles after redirect_i is sampled high.
  - Steady-state throughput is 1 instruction/cycle with inst_ready_i held high.
- Full with no pop: fetch_pc holds and rom_addr_o holds.
- Empty with inst_ready_i high: no pop; count never underflows.
- Reset mid-operation (rstn low at any time): immediately clears valid, contents and fetch_pc to the reset values. The first post-reset fetch is RESET_PC.
- Control is a 2-state FSM:
  - IDLE: only during reset; exits to RUN on the first edge after rstn high.
  - RUN: normal fetch.
  - IDLE suppresses push for the single cycle after reset release, so the ROM address is stable first. First valid is therefore 2 cycles after rstn deasserts. This figure is authoritative and supersedes the first-instruction latency above.

Decomposition:
- Shared package (riscv_pkg):
  - RESET_PC default.
  - INST_NOP = 32'h0000_0013.
  - Instruction width = 32, PC width = 32, PC step = 4.
- Sub-module inst_fifo: parameterised by DEPTH and entry width (64). Ports: push, pop, flush, wdata, rdata, count. Flush is synchronous.
- The if_prefetch top holds fetch_pc, the FSM and the push/pop/redirect logic.

Test Plan:
- Reset release, inst_ready_i=1, ROM returns addr^32'hA5A5_0000:
  - inst_valid_o rises 2 cycles after rstn.
  - pc_o = 0, 4, 8, C on consecutive cycles, each inst_o matching ROM.
- inst_ready_i=0 for 8 cycles:
  - count reaches 4 and rom_addr_o stalls at 0x10.
  - On ready=1, pc_o = 0, 4, 8, C, 10 with no gaps or duplicates.
- 3 entries buffered, redirect_i=1 with redirect_pc_i=0x100:
  - inst_valid_o = 0 the next cycle.
  - pc_o = 0x100 two cycles after redirect, then 0x104; no entry with pc < 0x100 appears.
- redirect_pc_i = 0x0000_0103: first delivered pc_o = 0x100.
- FIFO full with inst_ready_i=1 held: count stays 4 and one instruction is accepted per cycle; fetch_pc advances by 4 each cycle.
- Redirect to 0xFFFF_FFF8, ready=1: pc_o = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rstn pulled low asynchronously mid-stream: inst_valid_o = 0 and rom_addr_o = RESET_PC before the next clock edge.
